wasm_code_fetch_responder: RTL and testbench
============================================

Name: wasm_code_fetch_responder

Overview:
- Responder side of the instruction-fetch interface. Accepts fetch requests carrying a 128-bit instruction pointer (function index plus byte offset) and returns an 8-byte little-endian bytecode window.
- Holds the code memory (32-bit words, byte-addressed view) and a per-function base/length table, both written by the module loader.
- Sits between the fetcher unit (initiator) and the loaded WASM code image.

Parameters:
- CODE_WORDS, 1024, depth of code memory in 32-bit words.
- FUNC_MAX, 64, number of function table entries.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  fetch request valid
- req_ready  output  1  responder can accept a request
- req_ptr  input  128  [127:96] function index, [31:0] byte offset within function; other bits ignored
- rsp_valid  output  1  response valid
- rsp_ready  input  1  fetcher accepts response
- rsp_instr  output  64  bytecode window; byte 0 in [7:0]
- rsp_fault  output  1  request out of range; rsp_instr is 0 when set
- ftab_we  input  1  function table write strobe
- ftab_idx  input  $clog2(FUNC_MAX)  table entry index
- ftab_base  input  32  function code start, byte address
- ftab_len  input  32  function code length, bytes
- code_we  input  1  code memory write strobe
- code_ready  output  1  code write accepted this cycle
- code_waddr  input  $clog2(CODE_WORDS)  word address
- code_wdata  input  32  code word, little-endian bytes

Behaviour:
- Reset (async, immediate): FSM to IDLE; req_ready=1, rsp_valid=0, rsp_instr=0, rsp_fault=0, code_ready=1; every ftab entry base=0, len=0. Code memory contents are not reset.
- FSM states and transitions:
  - IDLE: on req_valid, latch req_ptr, look up the table, go to CHECK.
  - CHECK: compute A = base+offset as a 33-bit sum; set W = A[..:2], sh = A[1:0].
    - Fault if fidx >= FUNC_MAX, offset >= len, or A >= CODE_WORDS*4. On fault go to RESP with fault=1.
    - Otherwise issue a read of word W and go to RD1.
  - RD1: capture word W, issue read of W+1, go to RD2.
  - RD2: capture W+1, issue read of W+2, go to ASM.
  - ASM: capture W+2, form {w2,w1,w0} >> (8*sh), take the low 64 bits, go to RESP.
  - RESP: hold rsp_valid=1 with stable rsp_instr/rsp_fault until rsp_ready; then go to IDLE.
- Code memory reads are synchronous with 1-cycle latency. Word addresses >= CODE_WORDS read as 0.
- Bytes at function offset >= len (window crossing the function end) are forced to 0x00. There is no fault in that case.
- Latency: request accepted at edge T gives rsp_valid at T+4 for a normal fetch and T+2 for a fault. Zero-wait rsp_ready returns to IDLE one cycle later.
- req_ready=1 only in IDLE; one outstanding request at a time.
- Table writes are accepted in any state, take effect next cycle, and do not affect an in-flight request, which uses its latched base/len.
- Code writes:
  - code_ready=1 only in IDLE and when req_valid=0, so a request wins over a same-cycle write.
  - A write with code_ready=0 is not performed; the loader holds code_we until code_ready.
- rsp_ready held high in IDLE has no effect.
- Reset mid-operation drops any in-flight request and response without emitting them.

Test Plan:
- Aligned fetch: ftab[0]={base=0x100,len=32}, words 0x40..0x42 = 0x03020100, 0x07060504, 0x0B0A0908; req fidx=0 off=0 -> rsp_instr=0x0706050403020100, fault=0, rsp_valid 4 cycles after accept.
- Unaligned fetch: same image, off=3 -> rsp_instr=0x0A09080706050403.
- Function end padding: len=6, off=2 -> rsp_instr=0x0000000005040302, fault=0.
- Faults:
  - off=6 with len=6 -> fault=1, rsp_instr=0.
  - fidx=64 -> fault=1.
  - Unprogrammed fidx=5 -> fault=1.
  - Each at 2-cycle latency.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable and req_ready=0; release -> IDLE.
- Collision and reset:
  - code_we and req_valid in the same IDLE cycle -> code_ready=0, write deferred and lands later.
  - Assert rst during RD2 -> rsp_valid=0, req_ready=1 immediately, table zeroed.

Source files
------------

// File: rtl/wasm_code_fetch_responder_if.sv
// Instruction-fetch handshake between the fetcher (master) and the code responder (slave).
interface wasm_code_fetch_responder_if;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_ptr;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [63:0]  rsp_instr;
  logic         rsp_fault;

  modport master (
    output req_valid, req_ptr, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_fault
  );

  modport slave (
    input  req_valid, req_ptr, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_fault
  );
endinterface

// File: rtl/wasm_code_fetch_responder.sv
// Responder for WASM instruction fetch: per-function base/length table plus
// word-wide code memory; returns an 8-byte little-endian window per request.
module wasm_code_fetch_responder #(
  parameter int CODE_WORDS = 1024,
  parameter int FUNC_MAX   = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  wasm_code_fetch_responder_if.slave    fetch,
  input  logic                          ftab_we,
  input  logic [$clog2(FUNC_MAX)-1:0]   ftab_idx,
  input  logic [31:0]                   ftab_base,
  input  logic [31:0]                   ftab_len,
  input  logic                          code_we,
  output logic                          code_ready,
  input  logic [$clog2(CODE_WORDS)-1:0] code_waddr,
  input  logic [31:0]                   code_wdata
);

  localparam int IDXW = $clog2(FUNC_MAX);
  localparam int AW   = $clog2(CODE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD1,
    S_RD2,
    S_ASM,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic [31:0] tab_base [FUNC_MAX];
  logic [31:0] tab_len  [FUNC_MAX];
  logic [31:0] mem      [CODE_WORDS];

  logic [31:0] fidx_q, off_q, base_q, len_q;
  logic [31:0] w_q;
  logic [1:0]  sh_q;
  logic        fault_q;
  logic [31:0] w0_q, w1_q;
  logic [63:0] instr_q;
  logic        rsp_fault_q;

  logic [31:0] rd_addr;
  logic [31:0] rd_data;
  logic [32:0] sum;
  logic        chk_fault;
  logic [95:0] cat;
  logic [95:0] shifted;
  logic [63:0] win;

  logic unused_ptr_bits;
  assign unused_ptr_bits = ^fetch.req_ptr[95:32];

  // Address and range checks on the latched request.
  always_comb begin
    sum       = {1'b0, base_q} + {1'b0, off_q};
    chk_fault = (fidx_q >= 32'(FUNC_MAX)) || (off_q >= len_q) ||
                (sum >= 33'(CODE_WORDS) * 33'd4);
  end

  // Window assembly: shift the three fetched words, then blank bytes past the function end.
  always_comb begin
    cat     = {rd_data, w1_q, w0_q};
    shifted = cat >> {sh_q, 3'b000};
    win     = shifted[63:0];
    for (int unsigned i = 0; i < 8; i++) begin
      if (({1'b0, off_q} + 33'(i)) >= {1'b0, len_q}) begin
        win[8*i +: 8] = '0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; a faulting request spends one cycle in RD1 so faults answer two cycles after accept.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fetch.req_valid) state_nxt = S_CHECK;
      S_CHECK: state_nxt = S_RD1;
      S_RD1:   state_nxt = fault_q ? S_RESP : S_RD2;
      S_RD2:   state_nxt = S_ASM;
      S_ASM:   state_nxt = S_RESP;
      S_RESP:  if (fetch.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs and code-memory read address.
  always_comb begin
    fetch.req_ready = (state == S_IDLE);
    fetch.rsp_valid = (state == S_RESP);
    code_ready      = (state == S_IDLE) && !fetch.req_valid;
    rd_addr         = '0;
    unique case (state)
      S_CHECK: rd_addr = {1'b0, sum[32:2]};
      S_RD1:   rd_addr = w_q + 32'd1;
      S_RD2:   rd_addr = w_q + 32'd2;
      default: rd_addr = '0;
    endcase
  end

  assign fetch.rsp_instr = instr_q;
  assign fetch.rsp_fault = rsp_fault_q;

  // Code memory: loader write port and one-cycle synchronous read; out-of-range words read as zero.
  always_ff @(posedge clk) begin
    if (code_we && code_ready) mem[code_waddr] <= code_wdata;
    rd_data <= (rd_addr < 32'(CODE_WORDS)) ? mem[rd_addr[AW-1:0]] : '0;
  end

  // Function table, cleared on reset and writable in any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FUNC_MAX; i++) begin
        tab_base[i] <= '0;
        tab_len[i]  <= '0;
      end
    end else if (ftab_we) begin
      tab_base[ftab_idx] <= ftab_base;
      tab_len[ftab_idx]  <= ftab_len;
    end
  end

  // Request datapath: latch pointer and table entry, then collect words and build the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fidx_q      <= '0;
      off_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      w_q         <= '0;
      sh_q        <= '0;
      fault_q     <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      instr_q     <= '0;
      rsp_fault_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fetch.req_valid) begin
            fidx_q <= fetch.req_ptr[127:96];
            off_q  <= fetch.req_ptr[31:0];
            base_q <= tab_base[fetch.req_ptr[96 +: IDXW]];
            len_q  <= tab_len[fetch.req_ptr[96 +: IDXW]];
          end
        end
        S_CHECK: begin
          w_q     <= {1'b0, sum[32:2]};
          sh_q    <= sum[1:0];
          fault_q <= chk_fault;
        end
        S_RD1: begin
          w0_q <= rd_data;
          if (fault_q) begin
            instr_q     <= '0;
            rsp_fault_q <= 1'b1;
          end
        end
        S_RD2: w1_q <= rd_data;
        S_ASM: begin
          instr_q     <= win;
          rsp_fault_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_code_fetch_responder.sv
// Scoreboard bench for wasm_code_fetch_responder: expectations come from a
// byte-level reference model of the code image and function table.
module tb_wasm_code_fetch_responder;
  localparam int CODE_WORDS = 1024;
  localparam int FUNC_MAX   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ftab_we = 1'b0;
  logic [5:0]  ftab_idx = '0;
  logic [31:0] ftab_base = '0;
  logic [31:0] ftab_len = '0;
  logic        code_we = 1'b0;
  logic        code_ready;
  logic [9:0]  code_waddr = '0;
  logic [31:0] code_wdata = '0;

  always #5 clk = ~clk;

  wasm_code_fetch_responder_if fif ();

  wasm_code_fetch_responder #(
    .CODE_WORDS(CODE_WORDS),
    .FUNC_MAX  (FUNC_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fetch     (fif),
    .ftab_we   (ftab_we),
    .ftab_idx  (ftab_idx),
    .ftab_base (ftab_base),
    .ftab_len  (ftab_len),
    .code_we   (code_we),
    .code_ready(code_ready),
    .code_waddr(code_waddr),
    .code_wdata(code_wdata)
  );

  typedef struct {
    logic [63:0] instr;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl_mem  [CODE_WORDS];
  logic [31:0] mdl_base [FUNC_MAX];
  logic [31:0] mdl_len  [FUNC_MAX];

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] fidx, input logic [31:0] off);
    exp_t        e;
    logic [31:0] b, l, word;
    logic [32:0] o, a;
    e.instr = '0;
    e.fault = 1'b0;
    e.lat   = 4;
    if (fidx >= 32'(FUNC_MAX)) begin
      e.fault = 1'b1;
      e.lat   = 2;
      return e;
    end
    b = mdl_base[fidx[5:0]];
    l = mdl_len[fidx[5:0]];
    if ((off >= l) || (({1'b0, b} + {1'b0, off}) >= 33'(CODE_WORDS * 4))) begin
      e.fault = 1'b1;
      e.lat   = 2;
      return e;
    end
    for (int i = 0; i < 8; i++) begin
      o = {1'b0, off} + 33'(i);
      if (o < {1'b0, l}) begin
        a = {1'b0, b} + o;
        if (a < 33'(CODE_WORDS * 4)) begin
          word = mdl_mem[a[11:2]] >> (8 * int'(a[1:0]));
          e.instr[8*i +: 8] = word[7:0];
        end
      end
    end
    return e;
  endfunction

  task automatic write_ftab(input logic [5:0] idx, input logic [31:0] base, input logic [31:0] len);
    ftab_we   = 1'b1;
    ftab_idx  = idx;
    ftab_base = base;
    ftab_len  = len;
    tick();
    ftab_we = 1'b0;
    mdl_base[idx] = base;
    mdl_len[idx]  = len;
  endtask

  task automatic write_code(input logic [9:0] addr, input logic [31:0] data);
    int n;
    code_we    = 1'b1;
    code_waddr = addr;
    code_wdata = data;
    #1;
    n = 0;
    while (!code_ready && n < 50) begin
      tick();
      n++;
    end
    if (!code_ready) check_eq("code_ready_timeout", 64'(code_ready), 64'd1);
    tick();
    code_we = 1'b0;
    mdl_mem[addr] = data;
  endtask

  task automatic launch(input logic [31:0] fidx, input logic [31:0] off);
    fif.req_valid = 1'b1;
    fif.req_ptr   = {fidx, 64'hA5A5_5A5A_C3C3_3C3C, off};
    sb.push_back(model(fidx, off));
    check_eq("req_ready_idle", 64'(fif.req_ready), 64'd1);
  endtask

  task automatic finish(input int hold);
    exp_t        e;
    int          lat;
    logic [63:0] held;
    tick();
    fif.req_valid = 1'b0;
    lat = 0;
    while (!fif.rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    e = sb.pop_front();
    if (!fif.rsp_valid) begin
      check_eq("rsp_timeout", 64'(fif.rsp_valid), 64'd1);
      return;
    end
    check_eq("latency", 64'(lat), 64'(e.lat));
    check_eq("rsp_instr", fif.rsp_instr, e.instr);
    check_eq("rsp_fault", 64'(fif.rsp_fault), 64'(e.fault));
    check_eq("req_ready_busy", 64'(fif.req_ready), 64'd0);
    held = fif.rsp_instr;
    for (int i = 0; i < hold; i++) begin
      tick();
      check_eq("bp_valid", 64'(fif.rsp_valid), 64'd1);
      check_eq("bp_instr", fif.rsp_instr, held);
      check_eq("bp_req_ready", 64'(fif.req_ready), 64'd0);
    end
    fif.rsp_ready = 1'b1;
    tick();
    fif.rsp_ready = 1'b0;
    check_eq("rsp_valid_drop", 64'(fif.rsp_valid), 64'd0);
    check_eq("req_ready_back", 64'(fif.req_ready), 64'd1);
  endtask

  task automatic fetch(input logic [31:0] fidx, input logic [31:0] off, input int hold);
    launch(fidx, off);
    finish(hold);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    fif.req_valid = 1'b0;
    fif.req_ptr   = '0;
    fif.rsp_ready = 1'b0;
    for (int i = 0; i < CODE_WORDS; i++) mdl_mem[i] = '0;
    for (int i = 0; i < FUNC_MAX; i++) begin
      mdl_base[i] = '0;
      mdl_len[i]  = '0;
    end

    repeat (3) tick();
    check_eq("rst_req_ready", 64'(fif.req_ready), 64'd1);
    check_eq("rst_rsp_valid", 64'(fif.rsp_valid), 64'd0);
    check_eq("rst_rsp_instr", fif.rsp_instr, 64'd0);
    check_eq("rst_rsp_fault", 64'(fif.rsp_fault), 64'd0);
    check_eq("rst_code_ready", 64'(code_ready), 64'd1);
    rst = 1'b0;
    tick();

    // rsp_ready high while idle must not produce a response
    fif.rsp_ready = 1'b1;
    repeat (3) tick();
    check_eq("idle_rsp_ready", 64'(fif.rsp_valid), 64'd0);
    fif.rsp_ready = 1'b0;

    write_code(10'h040, 32'h0302_0100);
    write_code(10'h041, 32'h0706_0504);
    write_code(10'h042, 32'h0B0A_0908);
    write_code(10'h043, 32'h0F0E_0D0C);
    write_code(10'h044, 32'h1312_1110);
    write_code(10'h045, 32'h1716_1514);
    write_code(10'h046, 32'h1B1A_1918);
    write_code(10'h047, 32'h1F1E_1D1C);
    write_code(10'h3FF, 32'h4433_2211);
    write_ftab(6'd0, 32'h100, 32'd32);
    write_ftab(6'd1, 32'h100, 32'd6);
    write_ftab(6'd2, 32'hFFC, 32'd32);

    check_eq("model_aligned", model(32'd0, 32'd0).instr, 64'h0706_0504_0302_0100);
    fetch(32'd0, 32'd0, 0);
    fetch(32'd0, 32'd3, 0);
    fetch(32'd1, 32'd2, 0);
    fetch(32'd1, 32'd6, 0);
    fetch(32'd64, 32'd0, 0);
    fetch(32'd5, 32'd0, 0);
    fetch(32'd2, 32'd0, 0);
    fetch(32'd2, 32'd1, 0);
    fetch(32'd2, 32'd4, 0);
    fetch(32'd0, 32'd1, 5);

    for (int i = 0; i < 6; i++) fetch(32'd0, 32'($urandom_range(0, 31)), 0);

    // request and code write in the same idle cycle: request wins, write lands afterwards
    code_we    = 1'b1;
    code_waddr = 10'h041;
    code_wdata = 32'hDEAD_BEEF;
    launch(32'd0, 32'd0);
    #1;
    check_eq("collide_code_ready", 64'(code_ready), 64'd0);
    finish(0);
    write_code(10'h041, 32'hDEAD_BEEF);
    fetch(32'd0, 32'd4, 0);

    // reset while the request sits in RD2
    launch(32'd0, 32'd0);
    tick();
    fif.req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_eq("midrst_rsp_valid", 64'(fif.rsp_valid), 64'd0);
    check_eq("midrst_req_ready", 64'(fif.req_ready), 64'd1);
    void'(sb.pop_front());
    for (int i = 0; i < FUNC_MAX; i++) begin
      mdl_base[i] = '0;
      mdl_len[i]  = '0;
    end
    tick();
    rst = 1'b0;
    repeat (4) begin
      tick();
      check_eq("postrst_rsp_valid", 64'(fif.rsp_valid), 64'd0);
    end
    fetch(32'd0, 32'd0, 0);
    write_ftab(6'd0, 32'h100, 32'd32);
    fetch(32'd0, 32'd2, 0);

    check_eq("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
